pdec_llr_issue: RTL

Sequencer that drives the LLR-delivery interface into the PM update stage of the polar decoder. On a start command from the top controller it latches the surviving-path mask, reads the leaf-node LLR beats from the LLR buffer, and presents them to the PM units. Each transfer is one `ulr2upm_llr_st` cycle followed by N `ulr2upm_llr_en` beats. It then holds off the next command until the PM stage reports `upm2ctrl_upm_done`.

---
 rtl/pdec_pkg.sv | 25 ++
 rtl/pdec_llr_issue_if.sv | 35 +++
 rtl/pdec_lane_mask.sv | 25 ++
 rtl/pdec_llr_issue.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pdec_pkg.sv
// Shared types and codes for the polar-decoder LLR issue sequencer.
package pdec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] PATH_CK  = 2'd0;
  localparam logic [1:0] PATH_VLD = 2'd1;
  localparam logic [1:0] PATH_INV = 2'd3;

  localparam logic [1:0] STAGE_L1  = 2'd0;
  localparam logic [1:0] STAGE_L2  = 2'd1;
  localparam logic [1:0] STAGE_L4  = 2'd2;
  localparam logic [1:0] STAGE_L4B = 2'd3;

  // Code 2 is unassigned and is handled the same way as an invalid path.
  function automatic logic path_active(input logic [1:0] code);
    return !((code == PATH_INV) || (code == 2'd2));
  endfunction

endpackage

// File: rtl/pdec_llr_issue_if.sv
// Control, LLR-buffer and PM-delivery signals of the LLR issue sequencer.
interface pdec_llr_issue_if #(
  parameter int WID_INN  = 10,
  parameter int NUM_PATH = 8,
  parameter int WID_LEN  = 4
);
  logic                            ctrl2lis_start;
  logic [WID_LEN-1:0]              ctrl2lis_beat_num;
  logic [1:0]                      ctrl2lis_stage;
  logic [2*NUM_PATH-1:0]           path_valid;
  logic                            lis2mem_rd_en;
  logic [WID_LEN-1:0]              lis2mem_rd_addr;
  logic [WID_INN*4*NUM_PATH-1:0]   mem2lis_rd_data;
  logic [NUM_PATH-1:0]             ulr2upm_llr_st;
  logic [NUM_PATH-1:0]             ulr2upm_llr_en;
  logic [WID_INN*4*NUM_PATH-1:0]   ulr2upm_llr_data;
  logic                            upm2ctrl_upm_done;
  logic                            lis2ctrl_busy;
  logic                            lis2ctrl_done;
  logic                            lis2ctrl_err;

  modport master (
    input  ctrl2lis_start, ctrl2lis_beat_num, ctrl2lis_stage, path_valid,
           mem2lis_rd_data, upm2ctrl_upm_done,
    output lis2mem_rd_en, lis2mem_rd_addr, ulr2upm_llr_st, ulr2upm_llr_en,
           ulr2upm_llr_data, lis2ctrl_busy, lis2ctrl_done, lis2ctrl_err
  );

  modport slave (
    output ctrl2lis_start, ctrl2lis_beat_num, ctrl2lis_stage, path_valid,
           mem2lis_rd_data, upm2ctrl_upm_done,
    input  lis2mem_rd_en, lis2mem_rd_addr, ulr2upm_llr_st, ulr2upm_llr_en,
           ulr2upm_llr_data, lis2ctrl_busy, lis2ctrl_done, lis2ctrl_err
  );
endinterface

// File: rtl/pdec_lane_mask.sv
// One path's LLR lanes: gated by the beat enable and trimmed to the stage lane width.
module pdec_lane_mask
  import pdec_pkg::*;
#(
  parameter int WID_INN = 10
) (
  input  logic [4*WID_INN-1:0] i_data,
  input  logic                 i_en,
  input  logic [1:0]           i_stage,
  output logic [4*WID_INN-1:0] o_data
);

  always_comb begin
    o_data = '0;
    if (i_en) begin
      case (i_stage)
        STAGE_L1:            o_data[WID_INN-1:0]   = i_data[WID_INN-1:0];
        STAGE_L2:            o_data[2*WID_INN-1:0] = i_data[2*WID_INN-1:0];
        STAGE_L4, STAGE_L4B: o_data                = i_data;
        default:             o_data                = '0;
      endcase
    end
  end

endmodule

// File: rtl/pdec_llr_issue.sv
// LLR issue sequencer: latches the path mask, streams N buffer beats to the PM
// units behind one start cycle, then waits for the PM stage to finish.
module pdec_llr_issue
  import pdec_pkg::*;
#(
  parameter int WID_INN  = 10,
  parameter int NUM_PATH = 8,
  parameter int WID_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst,
  pdec_llr_issue_if.master  bus
);

  localparam int LANE_W = 4 * WID_INN;

  state_t                         r_state, w_state_nx;
  logic [NUM_PATH-1:0]            w_mask, r_mask;
  logic [1:0]                     r_stage;
  logic [WID_LEN-1:0]             r_beat_num;
  logic [WID_LEN-1:0]             r_cnt, w_cnt_nx;
  logic [WID_LEN:0]               w_addr_ahead;
  logic [NUM_PATH-1:0]            r_st, w_st_nx;
  logic [NUM_PATH-1:0]            r_en, w_en_nx;
  logic                           r_rd_en, w_rd_en_nx;
  logic [WID_LEN-1:0]             r_rd_addr, w_rd_addr_nx;
  logic                           r_busy;
  logic                           r_done, w_done_nx;
  logic                           r_err, w_err_nx;
  logic                           w_latch;
  logic [LANE_W*NUM_PATH-1:0]     w_llr_data;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_PATH; i++) begin
      w_mask[i] = path_active(bus.path_valid[2*i +: 2]);
    end
  end

  // Read one beat ahead: the buffer answers a cycle after rd_en.
  assign w_addr_ahead = {1'b0, r_cnt} + (WID_LEN+1)'(2);

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_st_nx      = '0;
    w_en_nx      = '0;
    w_rd_en_nx   = 1'b0;
    w_rd_addr_nx = '0;
    w_done_nx    = 1'b0;
    w_err_nx     = 1'b0;
    w_latch      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ctrl2lis_start) begin
          w_latch = 1'b1;
          if (w_mask != '0) begin
            w_state_nx = ST_PRE;
            w_st_nx    = w_mask;
            w_rd_en_nx = 1'b1;
          end else begin
            w_done_nx  = 1'b1;
          end
        end
      end
      ST_PRE: begin
        w_state_nx = ST_ISSUE;
        w_cnt_nx   = '0;
        w_en_nx    = r_mask;
        if (r_beat_num != '0) begin
          w_rd_en_nx   = 1'b1;
          w_rd_addr_nx = WID_LEN'(1);
        end
      end
      ST_ISSUE: begin
        if (r_cnt == r_beat_num) begin
          w_state_nx = ST_WAIT;
        end else begin
          w_en_nx  = r_mask;
          w_cnt_nx = r_cnt + WID_LEN'(1);
          if (w_addr_ahead <= {1'b0, r_beat_num}) begin
            w_rd_en_nx   = 1'b1;
            w_rd_addr_nx = w_addr_ahead[WID_LEN-1:0];
          end
        end
      end
      ST_WAIT: begin
        if (bus.upm2ctrl_upm_done) begin
          w_state_nx = ST_IDLE;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
    if (bus.ctrl2lis_start && (r_state != ST_IDLE)) begin
      w_err_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_st      <= '0;
      r_en      <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nx;
      r_st      <= w_st_nx;
      r_en      <= w_en_nx;
      r_rd_en   <= w_rd_en_nx;
      r_rd_addr <= w_rd_addr_nx;
      r_busy    <= (w_state_nx != ST_IDLE);
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
    end
  end

  // Transfer parameters only matter while r_en is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_latch) begin
      r_mask     <= w_mask;
      r_stage    <= bus.ctrl2lis_stage;
      r_beat_num <= bus.ctrl2lis_beat_num;
    end
  end

  for (genvar gi = 0; gi < NUM_PATH; gi++) begin : g_path
    pdec_lane_mask #(.WID_INN(WID_INN)) u_lane_mask (
      .i_data  (bus.mem2lis_rd_data[gi*LANE_W +: LANE_W]),
      .i_en    (r_en[gi]),
      .i_stage (r_stage),
      .o_data  (w_llr_data[gi*LANE_W +: LANE_W])
    );
  end

  assign bus.lis2mem_rd_en    = r_rd_en;
  assign bus.lis2mem_rd_addr  = r_rd_addr;
  assign bus.ulr2upm_llr_st   = r_st;
  assign bus.ulr2upm_llr_en   = r_en;
  assign bus.ulr2upm_llr_data = w_llr_data;
  assign bus.lis2ctrl_busy    = r_busy;
  assign bus.lis2ctrl_done    = r_done;
  assign bus.lis2ctrl_err     = r_err;

endmodule
